bin2bcd_wide: RTL and testbench
===============================

# bin2bcd_wide

Sequential double-dabble converter that turns the full 20-bit result of the Babbage difference engines into packed BCD digits. It sits directly downstream of the engine in the calculator datapath: the control FSM pulses `start` on the engine's `done_tick` and waits for this block's `done_tick` before driving the display mux. It covers the whole engine range, so values above 9999 are not truncated. It also reports which digits are leading zeros.

## Interface
- `BIN_W`, default 20: binary input width; also the number of shift iterations.
- `DIGITS`, default 7: BCD digits produced. The requirement 10^DIGITS > 2^BIN_W is checked at elaboration.
- `clk`  input  1: system clock, rising edge.
- `reset_n`  input  1: one clock; reset is asynchronous and active-low.
- `start`  input  1: one-cycle request. Sampled only when `ready`=1.
- `bin`  input  BIN_W: unsigned value. Captured in the cycle `start` is accepted.
- `ready`  output  1: high while idle.
- `done_tick`  output  1: one-cycle pulse when `bcd` holds a new result.
- `bcd`  output  4*DIGITS: packed result. Digit 0 is `bcd[3:0]`.
- `blank`  output  DIGITS: per-digit leading-zero flag. See Configuration.

## Operation
- FSM states: IDLE, OP, DONE.
  - IDLE -> OP on `start`.
  - OP -> DONE when the iteration counter reaches 0.
  - DONE -> IDLE unconditionally.
- Start accept (IDLE and `start`=1):
  - Shift register loads `bin`.
  - Working BCD register clears to 0.
  - Counter loads BIN_W.
- Each OP cycle:
  - Every 4-bit working digit that is >= 5 gets +3.
  - Then {working BCD, shift register} shifts left by one as a single register.
  - Counter decrements.
- Working BCD register is DIGITS*4 bits. The carry out of the top digit is discarded; it cannot occur given the elaboration check.
- Entering DONE: the output register `bcd` loads the working BCD value. `bcd` holds its previous result throughout OP.
- `ready` = (state==IDLE). `done_tick` = (state==DONE).
- `start` in OP or DONE is ignored. It is not queued.
- Changes on `bin` after the accept cycle have no effect.
- Reset values:
  - State IDLE.
  - `bcd`=0 and `blank`=0.
  - `ready`=1 and `done_tick`=0.
  - Counter and shift registers 0.
- Reset asserted mid-conversion aborts immediately. No `done_tick` is produced, and outputs return to reset values.

## Timing
- `start` accepted at cycle T. OP occupies T+1..T+BIN_W.
- `done_tick`=1 at T+BIN_W+1, together with the new `bcd`. This is cycle T+21 at the defaults.
- `ready`=0 from T+1 through T+BIN_W+1. It returns to 1 at T+BIN_W+2.
- Throughput: one conversion per BIN_W+2 cycles. A `start` held high continuously is re-accepted at T+BIN_W+2.
- All outputs are registered or state-decoded. There is no combinational path from `start` or `bin` to any output.

## Configuration
- Macro `BIN2BCD_LZB_EN` controls leading-zero blanking.
- Defined:
  - `blank[i]`=1 when digit i and every digit above it are zero, for i>=1.
  - `blank[0]` is always 0.
  - `blank` is registered and updates together with `bcd` on entering DONE.
- Undefined:
  - `blank` is tied to all zeros.
  - No blanking logic is synthesized.
  - The port stays present so the top level is unchanged.

## Structure
- The shared package holds:
  - The FSM state encoding: IDLE=2'b00, OP=2'b01, DONE=2'b10.
  - The BCD correction threshold (5) and offset (3) as named constants.
- One sub-module, `bcd_add3`: a combinational 4-bit digit corrector (if >=5 then +3).
  - Instantiated DIGITS times in a generate loop.

## Test plan
- Reset, then start with `bin`=0:
  - `done_tick` at exactly T+21.
  - `bcd`=0x0000000.
  - `blank`=7'b1111110 with LZB, 0 without.
- `bin`=20'hFFFFF (1048575) -> `bcd`=0x1048575 and `blank`=0 at T+21.
- `bin`=9999 -> `bcd`=0x0009999 and `blank`=7'b1110000. Then `bin`=10000 -> `bcd`=0x0010000.
- Start with 123; pulse `start` again with `bin`=456 at T+5 -> single `done_tick`, `bcd`=0x0000123. Second `start` ignored.
- Start with 500000; assert `reset_n`=0 at T+10 -> no `done_tick`, `bcd`=0, `ready`=1.
  - After release, start with 42 -> `bcd`=0x0000042 at 21 cycles.
- Hold `start`=1 with `bin` changing each cycle -> conversions accepted at T and T+22.
  - Each result matches the `bin` value captured at its accept cycle.

Source files
------------

// File: rtl/bin2bcd_wide_pkg.sv
// rtl/bin2bcd_wide_pkg.sv - shared FSM encoding, BCD correction constants and range check
package bin2bcd_wide_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_OP   = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam logic [3:0] ADD3_THRESHOLD = 4'd5;
  localparam logic [3:0] ADD3_OFFSET    = 4'd3;

  // 10^digits > 2^bin_w  <=>  digits*log2(10) > bin_w; log2(10) is irrational so ties never occur
  function automatic bit bcd_range_ok(input int bin_w, input int digits);
    return (longint'(digits) * 64'sd3321928095) > (longint'(bin_w) * 64'sd1000000000);
  endfunction

endpackage

// File: rtl/bin2bcd_wide_bcd_add3.sv
// rtl/bin2bcd_wide_bcd_add3.sv - combinational double-dabble digit corrector (>=5 then +3)
module bcd_add3
  import bin2bcd_wide_pkg::*;
(
  input  logic [3:0] digit,
  output logic [3:0] corrected
);

  assign corrected = (digit >= ADD3_THRESHOLD) ? (digit + ADD3_OFFSET) : digit;

endmodule

// File: rtl/bin2bcd_wide.sv
// rtl/bin2bcd_wide.sv - sequential BIN_W-bit to DIGITS-digit BCD converter; BIN2BCD_LZB_EN enables leading-zero blanking
module bin2bcd_wide
  import bin2bcd_wide_pkg::*;
#(
  parameter int BIN_W  = 20,
  parameter int DIGITS = 7
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  ready,
  output logic                  done_tick,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [DIGITS-1:0]     blank
);

  localparam int CNT_W = $clog2(BIN_W + 1);

  generate
    if (!bcd_range_ok(BIN_W, DIGITS)) begin : g_range_check
      $error("bin2bcd_wide: DIGITS too small to hold 2^BIN_W-1");
    end
  endgenerate

  state_t              state, state_next;
  logic [CNT_W-1:0]    count;
  logic [BIN_W-1:0]    shift;
  logic [4*DIGITS-1:0] work;
  logic [4*DIGITS-1:0] corrected;
  logic [4*DIGITS-1:0] work_shifted;
  logic                accept;
  logic                last_iter;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_add3 u_add3 (
      .digit     (work[4*i +: 4]),
      .corrected (corrected[4*i +: 4])
    );
  end

  // The top bit of the corrected top digit falls off: the range check guarantees it is zero.
  assign work_shifted = {corrected[4*DIGITS-2:0], shift[BIN_W-1]};
  assign accept       = (state == ST_IDLE) && start;
  assign last_iter    = (state == ST_OP) && (count == CNT_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start) state_next = ST_OP;
      ST_OP:   if (last_iter) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready     = (state == ST_IDLE);
    done_tick = (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      shift <= '0;
      work  <= '0;
      bcd   <= '0;
    end else begin
      if (accept) begin
        shift <= bin;
        work  <= '0;
        count <= CNT_W'(BIN_W);
      end else if (state == ST_OP) begin
        shift <= {shift[BIN_W-2:0], 1'b0};
        work  <= work_shifted;
        count <= count - 1'b1;
      end
      if (last_iter) bcd <= work_shifted;
    end
  end

`ifdef BIN2BCD_LZB_EN
  logic [DIGITS-1:0] blank_next;
  logic              zero_above;

  always_comb begin
    blank_next    = '0;
    zero_above    = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_above    = zero_above & (work_shifted[4*i +: 4] == 4'd0);
      blank_next[i] = zero_above;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       blank <= '0;
    else if (last_iter) blank <= blank_next;
  end
`else
  assign blank = '0;
`endif

endmodule

// File: tb/tb_bin2bcd_wide.sv
// tb/tb_bin2bcd_wide.sv - randomized self-checking bench for bin2bcd_wide against an arithmetic decimal model
module tb_bin2bcd_wide;

  localparam int BIN_W  = 20;
  localparam int DIGITS = 7;
  localparam int LAT    = BIN_W + 1;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                start;
  logic [BIN_W-1:0]    bin;
  logic                ready;
  logic                done_tick;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;

  int tests_run    = 0;
  int tests_failed = 0;

  bin2bcd_wide #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .bin       (bin),
    .ready     (ready),
    .done_tick (done_tick),
    .bcd       (bcd),
    .blank     (blank)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned         x;
    r = '0;
    x = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Digit i (i>=1) is a leading zero exactly when the value is below 10^i.
  function automatic logic [DIGITS-1:0] ref_blank(input int unsigned v);
    logic [DIGITS-1:0] b;
    longint unsigned   p;
    b = '0;
`ifdef BIN2BCD_LZB_EN
    p = 1;
    for (int i = 1; i < DIGITS; i++) begin
      p    = p * 10;
      b[i] = (longint'(v) < p);
    end
`else
    p = 0;
`endif
    return b;
  endfunction

  task automatic do_start(input logic [BIN_W-1:0] v);
    bin   = v;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_tick && lat < 100);
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    start   = 1'b0;
    bin     = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%b exp=1", ready); end
    tests_run++; if (done_tick !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done_tick); end
    tests_run++; if (bcd !== '0) begin tests_failed++; $display("FAIL reset_bcd got=%h exp=0", bcd); end
    tests_run++; if (blank !== '0) begin tests_failed++; $display("FAIL reset_blank got=%b exp=0", blank); end
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic convert_and_check(input string name, input logic [BIN_W-1:0] v);
    int lat;
    do_start(v);
    wait_done(lat);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL %s_latency v=%0d got=%0d exp=%0d", name, v, lat, LAT); end
    tests_run++; if (bcd !== ref_bcd(v)) begin tests_failed++; $display("FAIL %s_bcd v=%0d got=%h exp=%h", name, v, bcd, ref_bcd(v)); end
    tests_run++; if (blank !== ref_blank(v)) begin tests_failed++; $display("FAIL %s_blank v=%0d got=%b exp=%b", name, v, blank, ref_blank(v)); end
    @(posedge clk);
    #1;
    tests_run++; if (ready !== 1'b1 || done_tick !== 1'b0) begin tests_failed++; $display("FAIL %s_return_idle got ready=%b done=%b exp ready=1 done=0", name, ready, done_tick); end
  endtask

  task automatic test_corners;
    convert_and_check("zero", 20'd0);
    convert_and_check("max", 20'hFFFFF);
    convert_and_check("d9999", 20'd9999);
    convert_and_check("d10000", 20'd10000);
  endtask

  task automatic test_ignore_start;
    int lat;
    int extra;
    bin   = 20'd123;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    bin = 20'd0;
    repeat (4) @(posedge clk);
    #1 begin bin = 20'd456; start = 1'b1; end
    @(posedge clk);
    #1 begin start = 1'b0; bin = 20'd0; end
    lat = 5;
    do begin
      @(negedge clk);
      lat++;
    end while (!done_tick && lat < 100);
    tests_run++; if (lat !== LAT) begin tests_failed++; $display("FAIL ignore_latency got=%0d exp=%0d", lat, LAT); end
    tests_run++; if (bcd !== ref_bcd(123)) begin tests_failed++; $display("FAIL ignore_bcd got=%h exp=%h", bcd, ref_bcd(123)); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done_tick) extra++;
    end
    tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
    tests_run++; if (bcd !== ref_bcd(123)) begin tests_failed++; $display("FAIL ignore_bcd_hold got=%h exp=%h", bcd, ref_bcd(123)); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_abort;
    int ticks;
    do_start(20'd500000);
    repeat (9) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    tests_run++; if (ready !== 1'b1) begin tests_failed++; $display("FAIL abort_ready got=%b exp=1", ready); end
    tests_run++; if (done_tick !== 1'b0) begin tests_failed++; $display("FAIL abort_done got=%b exp=0", done_tick); end
    tests_run++; if (bcd !== '0) begin tests_failed++; $display("FAIL abort_bcd got=%h exp=0", bcd); end
    tests_run++; if (blank !== '0) begin tests_failed++; $display("FAIL abort_blank got=%b exp=0", blank); end
    @(posedge clk);
    #1 reset_n = 1'b1;
    ticks = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_tick) ticks++;
    end
    tests_run++; if (ticks !== 0) begin tests_failed++; $display("FAIL abort_no_done got=%0d exp=0", ticks); end
    @(posedge clk);
    #1;
    convert_and_check("after_abort", 20'd42);
  endtask

  task automatic test_back_to_back;
    localparam int N = 48;
    logic [BIN_W-1:0]    bin_hist   [N];
    logic                done_hist  [N];
    logic                ready_hist [N];
    logic [4*DIGITS-1:0] bcd_hist   [N];
    logic [DIGITS-1:0]   blank_hist [N];
    logic                exp_done;
    for (int k = 0; k < N; k++) begin
      bin_hist[k] = BIN_W'($urandom_range(0, 20'hFFFFF));
      bin   = bin_hist[k];
      start = 1'b1;
      @(negedge clk);
      done_hist[k]  = done_tick;
      ready_hist[k] = ready;
      bcd_hist[k]   = bcd;
      blank_hist[k] = blank;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      exp_done = (k == LAT) || (k == 2 * LAT + 1);
      tests_run++; if (done_hist[k] !== exp_done) begin tests_failed++; $display("FAIL b2b_done cycle=%0d got=%b exp=%b", k, done_hist[k], exp_done); end
    end
    tests_run++; if (ready_hist[1] !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_t1 got=%b exp=0", ready_hist[1]); end
    tests_run++; if (ready_hist[LAT] !== 1'b0) begin tests_failed++; $display("FAIL b2b_ready_t21 got=%b exp=0", ready_hist[LAT]); end
    tests_run++; if (ready_hist[LAT+1] !== 1'b1) begin tests_failed++; $display("FAIL b2b_ready_t22 got=%b exp=1", ready_hist[LAT+1]); end
    tests_run++; if (bcd_hist[LAT] !== ref_bcd(bin_hist[0])) begin tests_failed++; $display("FAIL b2b_bcd0 got=%h exp=%h", bcd_hist[LAT], ref_bcd(bin_hist[0])); end
    tests_run++; if (blank_hist[LAT] !== ref_blank(bin_hist[0])) begin tests_failed++; $display("FAIL b2b_blank0 got=%b exp=%b", blank_hist[LAT], ref_blank(bin_hist[0])); end
    tests_run++; if (bcd_hist[2*LAT+1] !== ref_bcd(bin_hist[LAT+1])) begin tests_failed++; $display("FAIL b2b_bcd1 got=%h exp=%h", bcd_hist[2*LAT+1], ref_bcd(bin_hist[LAT+1])); end
    tests_run++; if (bcd_hist[LAT-1] !== bcd_hist[1]) begin tests_failed++; $display("FAIL b2b_bcd_hold got=%h exp=%h", bcd_hist[LAT-1], bcd_hist[1]); end
    repeat (30) @(posedge clk);
    #1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 12; n++) begin
      convert_and_check("random", BIN_W'($urandom_range(0, 20'hFFFFF)));
    end
  endtask

  initial begin
    test_reset();
    test_corners();
    test_ignore_start();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
